// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin/burst-lock arbiter sharing BRAM port A, with a whole-RAM fill engine.
module bram_port_arbiter #(
   parameter int NUM_REQ       = 3,
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 8,
   parameter int MAX_BURST     = 4,
   parameter int FILL_ON_RESET = 1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ-1:0]         lock,
   input  logic [NUM_REQ-1:0]         we,
   input  logic [NUM_REQ*ADDR_W-1:0]  addr,
   input  logic [NUM_REQ*DATA_W-1:0]  wdata,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       rvalid,
   output logic [2:0]                 rid,
   output logic [DATA_W-1:0]          rdata,
   input  logic                       fill_start,
   input  logic [DATA_W-1:0]          fill_value,
   output logic                       fill_busy,
   output logic                       fill_done,
   output logic                       ram_wren,
   output logic [ADDR_W-1:0]          ram_address,
   output logic [DATA_W-1:0]          ram_data,
   input  logic [DATA_W-1:0]          ram_q
);
   typedef enum logic {ARB, FILL} state_t;
   localparam logic [3:0] N4   = 4'(NUM_REQ);
   localparam logic [2:0] LAST = 3'(NUM_REQ - 1);
   localparam logic [7:0] MB   = 8'(MAX_BURST);
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d, ram_addr_q;
   logic [DATA_W-1:0]   ram_data_q;
   logic [2:0]          rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, rid_q;
   logic [7:0]          burst_q, burst_d, req_x, lock_x, we_x, gnt_x;
   logic                rvalid_q, fill_done_q, hit, stay;
   logic [3:0]          idx;
   logic [ADDR_W-1:0]   addr_a  [8];
   logic [DATA_W-1:0]   wdata_a [8];
   assign req_x  = 8'(req);
   assign lock_x = 8'(lock);
   assign we_x   = 8'(we);
   for (genvar i = 0; i < 8; i++) begin : g_pad
      if (i < NUM_REQ) begin : g_used
         assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
         assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
      end else begin : g_zero
         assign addr_a[i]  = '0;
         assign wdata_a[i] = '0;
      end
   end
   // burst_q != 0 means the owner was granted in the previous cycle
   always_comb begin
      win  = '0;
      hit  = 1'b0;
      idx  = '0;
      stay = reset_n && state_q == ARB && burst_q != 8'd0 && burst_q < MB
             && req_x[owner_q] && lock_x[owner_q];
      if (stay) begin
         win = owner_q;
         hit = 1'b1;
      end else if (reset_n && state_q == ARB) begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + 4'(k);
            idx = idx >= N4 ? idx - N4 : idx;
            if (req_x[idx[2:0]]) begin
               win = idx[2:0];
               hit = 1'b1;
            end
         end
      end
   end
   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      burst_d     = '0;
      gnt_x       = '0;
      ram_wren    = 1'b0;
      ram_address = ram_addr_q;
      ram_data    = ram_data_q;
      fill_busy   = state_q == FILL;
      if (state_q == FILL) begin
         ram_wren    = 1'b1;
         ram_address = fill_addr_q;
         ram_data    = fill_value;
         fill_addr_d = fill_addr_q + 1'b1;
         state_d     = &fill_addr_q ? ARB : FILL;
      end else begin
         state_d = fill_start ? FILL : ARB;
         if (hit) begin
            gnt_x       = 8'd1 << win;
            ram_wren    = we_x[win];
            ram_address = addr_a[win];
            ram_data    = wdata_a[win];
            rr_ptr_d    = win == LAST ? 3'd0 : win + 3'd1;
            burst_d     = (win == owner_q && burst_q != 8'd0)
                          ? burst_q + {7'd0, burst_q != 8'hff} : 8'd1;
            owner_d     = win;
         end
      end
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= FILL_ON_RESET != 0 ? FILL : ARB;
         fill_addr_q <= '0;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         burst_q     <= '0;
         rvalid_q    <= 1'b0;
         rid_q       <= '0;
         fill_done_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         burst_q     <= burst_d;
         rvalid_q    <= hit && !we_x[win];
         rid_q       <= hit && !we_x[win] ? win : rid_q;
         fill_done_q <= state_q == FILL && &fill_addr_q;
         ram_addr_q  <= ram_address;
         ram_data_q  <= ram_data;
      end
   end
   assign gnt       = gnt_x[NUM_REQ-1:0];
   assign rvalid    = rvalid_q;
   assign rid       = rid_q;
   assign rdata     = ram_q;
   assign fill_done = fill_done_q;
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port (A) of the team's dual-clock dual-port block RAM among NUM_REQ requesters inside a single clock domain.
- Uses round-robin arbitration with optional burst lock.
- Contains a built-in fill engine that initialises the whole RAM to a constant after reset or on command.
- Sits between video/CPU-side clients and the RAM; port B stays free for the other clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 10, RAM address width; must match RAM widthad_a.
- DATA_W, 8, RAM data width; must match RAM width_a.
- MAX_BURST, 4, maximum consecutive grants to a locked owner (1..255).
- FILL_ON_RESET, 1, 1 = run the fill engine when reset deasserts.

Ports:
- clock  in  1  sole clock; also drives RAM clock_a.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request; held with cmd fields until the matching gnt bit.
- lock  in  NUM_REQ  per-requester burst-lock request, qualified by req.
- we  in  NUM_REQ  1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- gnt  out  NUM_REQ  one-hot, combinational; command accepted this cycle.
- rvalid  out  1  read data valid.
- rid  out  3  requester index for rvalid.
- rdata  out  DATA_W  read data (= ram_q).
- fill_start  in  1  start fill (pulse).
- fill_value  in  DATA_W  fill data; sampled each fill cycle.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse after the last fill write.
- ram_wren  out  1  to RAM wren_a.
- ram_address  out  ADDR_W  to RAM address_a.
- ram_data  out  DATA_W  to RAM data_a.
- ram_q  in  DATA_W  from RAM q_a (1-cycle registered read).

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low; all state is cleared asynchronously on reset_n low.
- Reset values:
  - state = FILL if FILL_ON_RESET else ARB.
  - fill_addr = 0, rr_ptr = 0, owner = 0, burst_cnt = 0.
  - rvalid = 0, rid = 0, fill_done = 0.
  - gnt = 0 while reset_n is low.
- FILL state:
  - ram_wren = 1, ram_address = fill_addr, ram_data = fill_value, gnt = 0, fill_busy = 1.
  - fill_addr increments each cycle.
  - At fill_addr = 2**ADDR_W-1: write the last address, go to ARB, clear fill_addr to 0, pulse fill_done in the first ARB cycle.
  - A fill of a 1024-word RAM takes exactly 1024 cycles.
  - fill_start during FILL is ignored.
- ARB state:
  - fill_busy = 0.
  - fill_start = 1 moves to FILL on the next edge. Grants in that same cycle still proceed; fill_start has no priority over a same-cycle grant.
- Arbitration (ARB state, combinational):
  - If owner has req[owner] & lock[owner], and burst_cnt < MAX_BURST, and owner was granted last cycle: grant owner.
  - Otherwise grant the first asserted req searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - With no req: gnt = 0, ram_wren = 0; ram_address/ram_data hold their last values (registered mux select, no X).
- Command path:
  - ram_wren = we[w], ram_address = addr[w], ram_data = wdata[w] for winner w, in the grant cycle.
- Updates on each grant to w:
  - rr_ptr <= (w+1) mod NUM_REQ.
  - If w == owner and the previous cycle granted owner: burst_cnt++ (saturating). Otherwise burst_cnt <= 1 and owner <= w.
- Burst cycle ending:
  - A cycle with no grant resets burst_cnt to 0.
  - Reaching MAX_BURST forces normal round-robin from rr_ptr on the next cycle; the owner may win again only if no other req is pending.
- Read return:
  - A read granted in cycle T gives rvalid = 1, rid = w, rdata = ram_q in cycle T+1.
  - Writes never assert rvalid.
  - Back-to-back reads yield back-to-back rvalid.
  - A read granted in the cycle fill_start is accepted still returns rvalid in the first FILL cycle.
- Reset mid-fill: the fill aborts; with FILL_ON_RESET=1 it restarts from address 0.
- gnt is never asserted for a requester whose req is low; at most one gnt bit is set.

Test Plan:
- Reset with FILL_ON_RESET=1, ADDR_W=4, fill_value=8'hA5 -> 16 writes to addresses 0..15, fill_done pulses at cycle 16, a subsequent read of address 7 returns rvalid with rdata=8'hA5 one cycle after gnt.
- req=3'b111 held, no lock, rr_ptr=0 -> gnt sequence 001,010,100,001 on consecutive cycles.
- Requester 1 with lock=1 and continuous req, requester 0 also requesting, MAX_BURST=4 -> gnt=010 for 4 cycles, then 001, then 010 again.
- Requester 2 writes 8'h3C to address 5, then requester 0 reads address 5 -> rvalid=1, rid=0, rdata=8'h3C in the cycle after the read grant.
- fill_start asserted in the same cycle as a read grant to requester 1 -> rvalid with rid=1 in the first FILL cycle, gnt=0 for the whole fill, fill_done pulse, then arbitration resumes.
- reset_n pulsed low at fill_addr=9 -> outputs return to reset values immediately, and the fill restarts from address 0.
